// File: rtl/prog_loader_pkg.sv
// Shared definitions for the UART program loader: receiver state encoding and word framing constants.
package prog_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    localparam logic [31:0] EOP_MARKER = 32'hFFFF_FFFF;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned IDX_W      = $clog2(WORD_BYTES);

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART byte receiver: rx synchronizer, mid-bit sampling FSM, and one-cycle byte/frame-error strobes.
module uart_rx
    import prog_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    input  logic       en_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    localparam int unsigned TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_END = TW'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]    sync_q;
    rx_state_e     state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          byte_valid_q, byte_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          rx_s;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= 2'b11;
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], rx_i};
            state_q      <= state_d;
            timer_q      <= timer_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Disabling aborts any frame in flight; stop-bit decision hands straight back to IDLE.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        if (!en_i) begin
            state_d   = ST_IDLE;
            timer_d   = '0;
            bit_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    timer_d = '0;
                    if (!rx_s) state_d = ST_START;
                end
                ST_START: begin
                    if (timer_q == HALF_END) begin
                        timer_d   = '0;
                        bit_cnt_d = '0;
                        state_d   = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                ST_DATA: begin
                    if (timer_q == BIT_END) begin
                        timer_d   = '0;
                        shift_d   = {rx_s, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_d = ST_STOP;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                ST_STOP: begin
                    if (timer_q == BIT_END) begin
                        timer_d      = '0;
                        state_d      = ST_IDLE;
                        byte_valid_d = rx_s;
                        frame_err_d  = !rx_s;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign byte_o       = shift_q;
    assign byte_valid_o = byte_valid_q;
    assign frame_err_o  = frame_err_q;
    assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: rtl/prog_loader.sv
// UART program loader: assembles big-endian 32-bit words from received bytes and writes them to
// instruction memory at consecutive addresses until the end-of-program marker arrives.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [31:0] BASE_ADDR    = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic        load_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        frame_err,
    output logic [15:0] word_count
);

    logic             rx_en;
    logic [7:0]       rx_byte;
    logic             rx_valid;
    logic             rx_ferr;
    logic             rx_busy;

    logic             load_en_q;
    logic             lockout_q, lockout_d;
    logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      addr_q, addr_d;
    logic [15:0]      count_q, count_d;
    logic             we_q, we_d;
    logic             done_q, done_d;
    logic             ferr_q, ferr_d;
    logic [31:0]      word_c;

    assign rx_en = load_en & ~lockout_q;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk         (clk),
        .rst_n       (reset),
        .rx_i        (rx),
        .en_i        (rx_en),
        .byte_o      (rx_byte),
        .byte_valid_o(rx_valid),
        .frame_err_o (rx_ferr),
        .busy_o      (rx_busy)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_en_q  <= 1'b0;
            lockout_q  <= 1'b0;
            byte_idx_q <= '0;
            wdata_q    <= '0;
            addr_q     <= BASE_ADDR;
            count_q    <= '0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            load_en_q  <= load_en;
            lockout_q  <= lockout_d;
            byte_idx_q <= byte_idx_d;
            wdata_q    <= wdata_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            we_q       <= we_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
        end
    end

    assign word_c = {wdata_q[23:0], rx_byte};

    // Word assembly, post-write address/count advance, and load_en edge handling.
    always_comb begin
        lockout_d  = lockout_q;
        byte_idx_d = byte_idx_q;
        wdata_d    = wdata_q;
        addr_d     = addr_q;
        count_d    = count_q;
        ferr_d     = ferr_q;
        we_d       = 1'b0;
        done_d     = 1'b0;
        if (we_q) begin
            addr_d = addr_q + 32'd4;
            if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
        end
        if (!load_en) begin
            byte_idx_d = '0;
            lockout_d  = 1'b0;
        end else begin
            if (!load_en_q) begin
                addr_d    = BASE_ADDR;
                count_d   = '0;
                ferr_d    = 1'b0;
                lockout_d = 1'b0;
            end
            if (rx_ferr) ferr_d = 1'b1;
            if (rx_valid && !lockout_q) begin
                wdata_d    = word_c;
                byte_idx_d = byte_idx_q + IDX_W'(1);
                if (byte_idx_q == IDX_W'(WORD_BYTES - 1)) begin
                    if (word_c == EOP_MARKER) begin
                        done_d    = 1'b1;
                        lockout_d = 1'b1;
                    end else begin
                        we_d = 1'b1;
                    end
                end
            end
        end
    end

    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign done       = done_q;
    assign frame_err  = ferr_q;
    assign word_count = count_q;
    assign busy       = rx_busy | (byte_idx_q != '0);

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200).
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0, byte address of the first word written.
REQ-003 The block SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1; reset is asynchronous and active-low.
REQ-005 The block SHALL have port rx, input, 1, asynchronous UART serial line, idle high.
REQ-006 The block SHALL have port load_en, input, 1, level; loading is active while high.
REQ-007 The block SHALL have port mem_we, output, 1, one-cycle write strobe to instruction memory.
REQ-008 The block SHALL have port mem_addr, output, 32, byte address of the word being written.
REQ-009 The block SHALL have port mem_wdata, output, 32, assembled instruction word.
REQ-010 The block SHALL have port busy, output, 1, high while a frame or a partial word is in progress.
REQ-011 The block SHALL have port done, output, 1, one-cycle pulse on end-of-program marker.
REQ-012 The block SHALL have port frame_err, output, 1, sticky framing-error flag.
REQ-013 The block SHALL have port word_count, output, 16, number of words written since load_en rose.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer before any use; latency 2 cycles is accepted.
REQ-015 The receiver FSM SHALL have states IDLE, START, DATA and STOP; frame format 8N1, LSB first.
REQ-016 In IDLE with load_en high, a synchronized low on rx SHALL move the FSM to START and clear the bit-timer.
REQ-017 In START, at timer = CLKS_PER_BIT/2 - 1, rx low SHALL move to DATA; rx high SHALL return to IDLE (glitch reject, no error).
REQ-018 In DATA, rx SHALL be sampled every CLKS_PER_BIT cycles (mid-bit); after 8 samples the FSM SHALL move to STOP.
REQ-019 In STOP, at mid-bit, rx high SHALL yield a valid byte; rx low SHALL set frame_err, discard the byte and leave the byte index unchanged.
REQ-020 From STOP the FSM SHALL return to IDLE immediately after the mid-bit sample, so back-to-back frames are accepted.
REQ-021 Valid bytes SHALL be assembled big-endian: the first byte lands in mem_wdata[31:24], the fourth in [7:0].
REQ-022 A 2-bit byte index SHALL wrap 3 -> 0 on the fourth valid byte.
REQ-023 On the fourth byte, if the word is not 32'hFFFFFFFF, mem_we SHALL pulse high in the next cycle with mem_addr/mem_wdata stable that cycle.
REQ-024 After each such write, mem_addr SHALL advance by 4 and word_count by 1; mem_addr SHALL wrap modulo 2^32 and word_count SHALL saturate at 16'hFFFF.
REQ-025 On the fourth byte, if the word equals 32'hFFFFFFFF, no write SHALL occur and done SHALL pulse high one cycle later.
REQ-026 After done, the block SHALL ignore rx until load_en falls and rises again.
REQ-027 When load_en falls, the block SHALL abort any frame, return to IDLE, clear the byte index and raise no strobes.
REQ-028 When load_en rises, the block SHALL set mem_addr to BASE_ADDR, clear word_count and frame_err, and clear the done-lockout.
REQ-029 busy SHALL be high when the FSM is not IDLE or the byte index is non-zero.
REQ-030 mem_we and done SHALL never be high in the same cycle.

Reset
REQ-031 When reset is low, asynchronously: FSM to IDLE, timer and bit counter 0, byte index 0, mem_we 0, done 0, busy 0, frame_err 0, mem_wdata 0, mem_addr BASE_ADDR, word_count 0, synchronizer flops 1.
REQ-032 A reset asserted mid-frame or mid-word SHALL discard partial data; no write or done pulse may follow its release.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding, the end-of-program marker 32'hFFFFFFFF and the word byte count 4.
REQ-034 The UART byte receiver (sync, FSM, timer) SHALL be a sub-module uart_rx that outputs byte plus a one-cycle byte_valid and frame_err strobe; prog_loader adds word assembly and addressing.

Verification (CLKS_PER_BIT = 16, BASE_ADDR = 0)
REQ-035 Send bytes 8C 01 00 04 -> one mem_we with mem_addr 0x0, mem_wdata 0x8C010004; word_count 1.
REQ-036 Send two words then FF FF FF FF, back-to-back -> writes at 0x0 and 0x4, then done pulse, no third write; further bytes ignored.
REQ-037 Send 12, then a frame with stop bit 0, then 34 56 78 -> frame_err set, single write of 0x12345678.
REQ-038 rx low pulse of 4 cycles while idle -> no byte, no frame_err, FSM back to IDLE.
REQ-039 Drop load_en after 2 bytes, re-raise, send AA BB CC DD -> write 0xAABBCCDD at 0x0; word_count 1.
REQ-040 Assert reset mid-DATA of the 3rd byte, release, re-raise load_en, send 4 bytes -> all outputs at reset values during reset; exactly one write at 0x0.
